// File: rtl/adc_capture_multi_if.sv
// ---------------------------------------------------------------------------
// adc_capture_multi_if
// Bundles the converter-side and sample-side signals of adc_capture_multi.
//
// Handshake: there is no back-pressure. sample_valid and avg_valid are
// single-cycle strobes. The word they qualify (sample, or avg/min_val/max_val)
// is valid in the same cycle and holds until the next strobe of that kind.
// A consumer must take the data in the strobe cycle or at any time before the
// next strobe.
//
// master (capture block) : in  en, ad_sdata
//                          out ad_cs, sample, sample_valid, avg, min_val,
//                              max_val, avg_valid, frame_cnt, state_dbg
// slave  (system side)   : the mirror of master
// ---------------------------------------------------------------------------
interface adc_capture_multi_if #(
  parameter int NUM_CH   = 4,
  parameter int RES_BITS = 12
);
  logic                         en;
  logic                         ad_cs;
  logic [NUM_CH-1:0]            ad_sdata;
  logic [NUM_CH*RES_BITS-1:0]   sample;
  logic                         sample_valid;
  logic [NUM_CH*RES_BITS-1:0]   avg;
  logic [NUM_CH*RES_BITS-1:0]   min_val;
  logic [NUM_CH*RES_BITS-1:0]   max_val;
  logic                         avg_valid;
  logic [15:0]                  frame_cnt;
  logic                         state_dbg;  // 1 = RUN, 0 = IDLE

  modport master (
    input  en, ad_sdata,
    output ad_cs, sample, sample_valid, avg, min_val, max_val, avg_valid,
           frame_cnt, state_dbg
  );

  modport slave (
    output en, ad_sdata,
    input  ad_cs, sample, sample_valid, avg, min_val, max_val, avg_valid,
           frame_cnt, state_dbg
  );
endinterface

// File: rtl/adc_capture_multi.sv
// ---------------------------------------------------------------------------
// adc_capture_multi
// Multi-lane serial A/D capture with per-channel boxcar decimation.
// One shared chip-select frames NUM_CH serial lanes, each deserialised MSB
// first. Every completed frame yields one raw sample word; every DECIM samples
// yield one average/min/max word per channel.
//
// Ports:
//   clk    in  system clock (converter serial clock is its inverse, external)
//   reset  in  synchronous, active-high
//   bus    adc_capture_multi_if.master:
//            en           run enable, looked at only at frame boundaries
//            ad_cs        registered chip-select, high = idle/convert start
//            ad_sdata     one serial lane per channel
//            sample       latest raw samples, ch0 in the LSBs
//            sample_valid one-cycle strobe for sample
//            avg/min_val/max_val  window results, ch0 in the LSBs
//            avg_valid    one-cycle strobe for the window results
//            frame_cnt    completed frames, wraps 0xFFFF -> 0
//            state_dbg    frame FSM state (1 = RUN)
// ---------------------------------------------------------------------------
module adc_capture_multi #(
  parameter int NUM_CH       = 4,
  parameter int RES_BITS     = 12,
  parameter int LEAD_BITS    = 2,
  parameter int FRAME_CYCLES = 16,
  parameter int DECIM        = 16
) (
  input  logic                clk,
  input  logic                reset,
  adc_capture_multi_if.master bus
);

  localparam int CNT_W = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
  localparam int SHIFT = $clog2(DECIM);
  localparam int ACC_W = RES_BITS + SHIFT;
  localparam int WIN_W = (DECIM > 1) ? SHIFT : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP_FIRST = CNT_W'(1 + LEAD_BITS);
  localparam logic [CNT_W-1:0] CAP_LAST  = CNT_W'(LEAD_BITS + RES_BITS);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(DECIM - 1);

  if (FRAME_CYCLES < 1 + LEAD_BITS + RES_BITS) begin : g_chk_frame
    $error("adc_capture_multi: FRAME_CYCLES must be >= 1+LEAD_BITS+RES_BITS");
  end
  if ((DECIM < 1) || ((DECIM & (DECIM - 1)) != 0)) begin : g_chk_decim
    $error("adc_capture_multi: DECIM must be a power of two >= 1");
  end
  if (RES_BITS < 2) begin : g_chk_res
    $error("adc_capture_multi: RES_BITS must be >= 2");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Frame sequencing
  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_ad_cs;
  logic               w_capture;
  logic               w_last;
  logic               r_last;

  // Capture
  logic [RES_BITS-1:0] r_shift  [NUM_CH];
  logic [RES_BITS-1:0] r_sample [NUM_CH];
  logic                r_sample_valid;
  logic [15:0]         r_frame_cnt;

  // Decimation
  logic [WIN_W-1:0]    r_win;
  logic [ACC_W-1:0]    r_acc     [NUM_CH];
  logic [ACC_W-1:0]    w_acc_tot [NUM_CH];
  logic [RES_BITS-1:0] r_run_min [NUM_CH];
  logic [RES_BITS-1:0] r_run_max [NUM_CH];
  logic [RES_BITS-1:0] w_min_nxt [NUM_CH];
  logic [RES_BITS-1:0] w_max_nxt [NUM_CH];
  logic [RES_BITS-1:0] r_avg     [NUM_CH];
  logic [RES_BITS-1:0] r_min_out [NUM_CH];
  logic [RES_BITS-1:0] r_max_out [NUM_CH];
  logic                r_avg_valid;

  logic [NUM_CH*RES_BITS-1:0] w_sample_flat;
  logic [NUM_CH*RES_BITS-1:0] w_avg_flat;
  logic [NUM_CH*RES_BITS-1:0] w_min_flat;
  logic [NUM_CH*RES_BITS-1:0] w_max_flat;

  // -------------------------------------------------------------------------
  // Frame FSM: en is only consulted when leaving IDLE or at the frame wrap,
  // so a frame in flight always runs to completion.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.en) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (r_cnt == CNT_LAST) begin
          if (!bus.en) w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_capture = (r_state == S_RUN) && (r_cnt >= CAP_FIRST) && (r_cnt <= CAP_LAST);
    w_last    = (r_state == S_RUN) && (r_cnt == CAP_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_ad_cs        <= 1'b1;
      r_last         <= 1'b0;
      r_sample_valid <= 1'b0;
      r_frame_cnt    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_shift[c]  <= '0;
        r_sample[c] <= '0;
      end
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      // Computed from next-state values so ad_cs lines up with r_cnt.
      r_ad_cs        <= (w_state_nxt == S_IDLE) || (w_cnt_nxt == '0);
      // r_last marks that the final bit landed on this edge; the sample word
      // is published one cycle later.
      r_last         <= w_last;
      r_sample_valid <= r_last;
      if (r_last) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
        for (int c = 0; c < NUM_CH; c++) r_sample[c] <= r_shift[c];
      end
      if (w_capture) begin
        for (int c = 0; c < NUM_CH; c++)
          r_shift[c] <= {r_shift[c][RES_BITS-2:0], bus.ad_sdata[c]};
      end
    end
  end

  // -------------------------------------------------------------------------
  // Decimation. Runs in the sample_valid cycle, when r_sample holds the new
  // word. The running extremes are re-seeded by the first sample of each
  // window (r_win == 0) rather than cleared, so no sentinel values are needed.
  // -------------------------------------------------------------------------
  always_comb begin
    w_sample_flat = '0;
    w_avg_flat    = '0;
    w_min_flat    = '0;
    w_max_flat    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_acc_tot[c] = r_acc[c] + ACC_W'(r_sample[c]);
      w_min_nxt[c] = r_run_min[c];
      w_max_nxt[c] = r_run_max[c];
      if ((r_win == '0) || (r_sample[c] < r_run_min[c])) w_min_nxt[c] = r_sample[c];
      if ((r_win == '0) || (r_sample[c] > r_run_max[c])) w_max_nxt[c] = r_sample[c];
      w_sample_flat[c*RES_BITS +: RES_BITS] = r_sample[c];
      w_avg_flat[c*RES_BITS +: RES_BITS]    = r_avg[c];
      w_min_flat[c*RES_BITS +: RES_BITS]    = r_min_out[c];
      w_max_flat[c*RES_BITS +: RES_BITS]    = r_max_out[c];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_win       <= '0;
      r_avg_valid <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_acc[c]     <= '0;
        r_run_min[c] <= '0;
        r_run_max[c] <= '0;
        r_avg[c]     <= '0;
        r_min_out[c] <= '0;
        r_max_out[c] <= '0;
      end
    end else begin
      r_avg_valid <= 1'b0;
      if (r_sample_valid) begin
        if (r_win == WIN_LAST) begin
          r_win       <= '0;
          r_avg_valid <= 1'b1;
          for (int c = 0; c < NUM_CH; c++) begin
            r_acc[c]     <= '0;
            // Truncating divide by DECIM: drop the low SHIFT bits.
            r_avg[c]     <= w_acc_tot[c][SHIFT +: RES_BITS];
            r_min_out[c] <= w_min_nxt[c];
            r_max_out[c] <= w_max_nxt[c];
          end
        end else begin
          r_win <= r_win + WIN_W'(1);
          for (int c = 0; c < NUM_CH; c++) begin
            r_acc[c]     <= w_acc_tot[c];
            r_run_min[c] <= w_min_nxt[c];
            r_run_max[c] <= w_max_nxt[c];
          end
        end
      end
    end
  end

  assign bus.ad_cs        = r_ad_cs;
  assign bus.sample       = w_sample_flat;
  assign bus.sample_valid = r_sample_valid;
  assign bus.avg          = w_avg_flat;
  assign bus.min_val      = w_min_flat;
  assign bus.max_val      = w_max_flat;
  assign bus.avg_valid    = r_avg_valid;
  assign bus.frame_cnt    = r_frame_cnt;
  assign bus.state_dbg    = (r_state == S_RUN);

endmodule
